// File: rtl/fp16_add_arbiter_if.sv
// Request/response bundle between two requesters and the shared fp16 adder arbiter.
// Signals:
//   req0_valid/req0_ready/req0_a/req0_b   requester 0 operation handshake and operands
//   req1_valid/req1_ready/req1_a/req1_b   requester 1 operation handshake and operands
//   req0_sub/req1_sub                     subtract select (only with FP_ADD_SUB_EN defined)
//   resp0_valid/resp0_ready               result handshake, requester 0
//   resp1_valid/resp1_ready               result handshake, requester 1
//   resp_data/resp_flags                  shared result and {N,Z,C,V} flags
// Modports: slave = arbiter side, master = requester side.
// Optional feature macro: FP_ADD_SUB_EN.
interface fp16_add_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RES_W  = 32,
  parameter int unsigned FLAG_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
`ifdef FP_ADD_SUB_EN
  logic              req0_sub;
  logic              req1_sub;
`endif
  logic              resp0_valid;
  logic              resp0_ready;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [RES_W-1:0]  resp_data;
  logic [FLAG_W-1:0] resp_flags;

  modport slave (
`ifdef FP_ADD_SUB_EN
    input  req0_sub, req1_sub,
`endif
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    input  resp0_ready, resp1_ready,
    output resp0_valid, resp1_valid, resp_data, resp_flags
  );

  modport master (
`ifdef FP_ADD_SUB_EN
    output req0_sub, req1_sub,
`endif
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    output resp0_ready, resp1_ready,
    input  resp0_valid, resp1_valid, resp_data, resp_flags
  );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one combinational fp16 adder between two requesters.
// The winner's operands are registered onto fpu_a/fpu_b, held for HOLD_CYCLES cycles,
// then the adder result/flags are captured and returned to the granted requester.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   bus (slave)         request/response handshakes, see fp16_add_arbiter_if
//   fpu_a, fpu_b        registered operands to the adder
//   fpu_result/flags    adder outputs
//   busy                high whenever the FSM is not IDLE
// Optional feature macro: FP_ADD_SUB_EN (per-request subtract select, flips sign of b).
module fp16_add_arbiter #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RES_W       = 32,
  parameter int unsigned FLAG_W      = 4,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  fp16_add_arbiter_if.slave   bus,
  output logic [DATA_W-1:0]   fpu_a,
  output logic [DATA_W-1:0]   fpu_b,
  input  logic [RES_W-1:0]    fpu_result,
  input  logic [FLAG_W-1:0]   fpu_flags,
  output logic                busy
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  if (HOLD_CYCLES == 0) begin : g_hold_check
    $error("fp16_add_arbiter: HOLD_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] fpu_a_q, fpu_a_d;
  logic [DATA_W-1:0] fpu_b_q, fpu_b_d;
  logic              resp0_valid_q, resp0_valid_d;
  logic              resp1_valid_q, resp1_valid_d;
  logic [RES_W-1:0]  resp_data_q, resp_data_d;
  logic [FLAG_W-1:0] resp_flags_q, resp_flags_d;
  logic              busy_q, busy_d;

  logic              win_c;
  logic              req0_ready_c;
  logic              req1_ready_c;
  logic [DATA_W-1:0] sel_a_c;
  logic [DATA_W-1:0] sel_b_c;

  // Winner: the only valid requester, or on a tie the one not granted last time.
  always_comb begin
    win_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      win_c = ~last_q;
    end else if (bus.req1_valid) begin
      win_c = 1'b1;
    end
  end

  // Operand select; optional subtract negates b by flipping its sign bit.
  always_comb begin
    sel_a_c = win_c ? bus.req1_a : bus.req0_a;
    sel_b_c = win_c ? bus.req1_b : bus.req0_b;
`ifdef FP_ADD_SUB_EN
    if (win_c ? bus.req1_sub : bus.req0_sub) begin
      sel_b_c = {~sel_b_c[DATA_W-1], sel_b_c[DATA_W-2:0]};
    end
`endif
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;
    resp_data_d   = resp_data_q;
    resp_flags_d  = resp_flags_q;
    req0_ready_c  = 1'b0;
    req1_ready_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ready is suppressed while reset is asserted so nothing looks accepted.
        req0_ready_c = !reset && bus.req0_valid && !win_c;
        req1_ready_c = !reset && bus.req1_valid &&  win_c;
        if (req0_ready_c || req1_ready_c) begin
          id_d    = win_c;
          last_d  = win_c;
          fpu_a_d = sel_a_c;
          fpu_b_d = sel_b_c;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          resp_data_d  = fpu_result;
          resp_flags_d = fpu_flags;
          if (id_q) begin
            resp1_valid_d = 1'b1;
          end else begin
            resp0_valid_d = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (id_q ? bus.resp1_ready : bus.resp0_ready) begin
          resp0_valid_d = 1'b0;
          resp1_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      id_q          <= 1'b0;
      last_q        <= 1'b1;
      cnt_q         <= '0;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp_data_q   <= '0;
      resp_flags_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp_data_q   <= resp_data_d;
      resp_flags_q  <= resp_flags_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req0_ready  = req0_ready_c;
  assign bus.req1_ready  = req1_ready_c;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_flags  = resp_flags_q;
  assign fpu_a           = fpu_a_q;
  assign fpu_b           = fpu_b_q;
  assign busy            = busy_q;

endmodule
